imem_uart_loader: RTL and testbench

// Writer side of the instruction memory. The processor only reads imem; this block fills it.
// It receives a program over UART (8N1, LSB first) and writes 32-bit words to the imem write port.
// It holds the processor in reset (cpu_rst) until a complete frame with a valid checksum has loaded.

---
 rtl/imem_uart_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader: receives a sync/length/payload/checksum frame and writes
// 32-bit big-endian words into imem, holding the CPU in reset until a good frame lands.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD         = 4096,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_we,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] HALF_M1   = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] WORD_N    = 16'(WORD);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        F_SYNC, F_LEN_HI, F_LEN_LO, F_DATA, F_CSUM, F_DONE, F_ERR
    } frame_state_t;

    rx_state_t    rx_state;
    frame_state_t fstate;

    logic              rxd_s1, rxd_s2, rxd_prev;
    logic [15:0]       rx_cnt;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              byte_vld, frame_err;

    logic [15:0]       len;
    logic [ADDR_W:0]   wcnt;
    logic [1:0]        bcnt;
    logic [23:0]       word_sh;
    logic [7:0]        csum;

    // Word count is ADDR_W+1 bits so that N == WORD is reachable.
    function automatic logic is_last_word(input logic [ADDR_W:0] w, input logic [15:0] n);
        return (16'(w) + 16'd1) == n;
    endfunction

    function automatic logic len_bad(input logic [15:0] n);
        return (n == 16'd0) || (n > WORD_N);
    endfunction

    // RX front end: synchronizer, mid-bit sampling, byte_vld / frame_err pulses at mid-stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1    <= 1'b1;
            rxd_s2    <= 1'b1;
            rxd_prev  <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxd_s1    <= rxd;
            rxd_s2    <= rxd_s1;
            rxd_prev  <= rxd_s2;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rxd_prev && !rxd_s2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_s2)
                            byte_vld <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame FSM: advances only on byte_vld or frame_err; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate     <= F_SYNC;
            imem_addr  <= '0;
            imem_wdata <= '0;
            imem_we    <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len        <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            word_sh    <= '0;
            csum       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (byte_vld) begin
                case (fstate)
                    F_SYNC, F_DONE, F_ERR: begin
                        if (rx_shift == SYNC_BYTE) begin
                            fstate  <= F_LEN_HI;
                            cpu_rst <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                            csum    <= '0;
                        end
                    end
                    F_LEN_HI: begin
                        len[15:8] <= rx_shift;
                        fstate    <= F_LEN_LO;
                    end
                    F_LEN_LO: begin
                        len[7:0] <= rx_shift;
                        if (len_bad({len[15:8], rx_shift})) begin
                            fstate  <= F_ERR;
                            err     <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            wcnt   <= '0;
                            bcnt   <= '0;
                            fstate <= F_DATA;
                        end
                    end
                    F_DATA: begin
                        word_sh <= {word_sh[15:0], rx_shift};
                        csum    <= csum ^ rx_shift;
                        bcnt    <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wcnt[ADDR_W-1:0];
                            imem_wdata <= {word_sh, rx_shift};
                            wcnt       <= wcnt + 1'b1;
                            if (is_last_word(wcnt, len))
                                fstate <= F_CSUM;
                        end
                    end
                    F_CSUM: begin
                        if (rx_shift == csum) begin
                            fstate  <= F_DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            fstate  <= F_ERR;
                            err     <= 1'b1;
                            cpu_rst <= 1'b1;
                        end
                    end
                    default: fstate <= F_SYNC;
                endcase
            end else if (frame_err) begin
                case (fstate)
                    F_LEN_HI, F_LEN_LO, F_DATA, F_CSUM: begin
                        fstate  <= F_ERR;
                        err     <= 1'b1;
                        cpu_rst <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table of frames plus hand-written corner sequences,
// with a write scoreboard fed when frames are sent and drained on each imem_we pulse.
module tb_imem_uart_loader;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_we;
    logic        cpu_rst;
    logic        done;
    logic        err;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .WORD(4096), .ADDR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string             name;
        int                nb;
        logic [15:0][7:0]  b;
        int                nw;
        logic [1:0][43:0]  w;
        logic              e_err;
        logic              e_done;
        logic              e_cpu;
    } vec_t;

    vec_t        vecs[5];
    vec_t        cur;
    logic [7:0]  t1 [11];
    logic [43:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        rise_seen;
    logic        done_at_rise;

    task automatic check(input string nm, input logic [43:0] act, input logic [43:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Write monitor / scoreboard, plus cpu_rst rising-edge capture.
    initial begin
        logic prev_cpu;
        logic [43:0] e;
        prev_cpu = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && imem_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("imem_write", {imem_addr, imem_wdata}, e);
                end
            end
            if (!prev_cpu && cpu_rst) begin
                rise_seen    = 1'b1;
                done_at_rise = done;
            end
            prev_cpu = cpu_rst;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        if (!stop_bit)
            repeat (CPB) @(posedge clk);
    endtask

    task automatic start_vec(input string nm, input logic ee, input logic ed, input logic ec);
        cur.name   = nm;
        cur.nb     = 0;
        cur.b      = '0;
        cur.nw     = 0;
        cur.w      = '0;
        cur.e_err  = ee;
        cur.e_done = ed;
        cur.e_cpu  = ec;
    endtask

    task automatic addb(input logic [7:0] x);
        cur.b[cur.nb] = x;
        cur.nb++;
    endtask

    task automatic add_t1(input logic [7:0] cs);
        for (int i = 0; i < 11; i++) addb(t1[i]);
        addb(cs);
        cur.w[0] = {12'h000, 32'h3C010001};
        cur.w[1] = {12'h001, 32'h00210820};
        cur.nw   = 2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},    44'(imem_addr),  44'h0);
        check({tag, "_wdata"},   44'(imem_wdata), 44'h0);
        check({tag, "_we"},      44'(imem_we),    44'h0);
        check({tag, "_cpu_rst"}, 44'(cpu_rst),    44'h1);
        check({tag, "_done"},    44'(done),       44'h0);
        check({tag, "_err"},     44'(err),        44'h0);
    endtask

    task automatic check_status(input string tag, input logic ee, input logic ed, input logic ec);
        check({tag, "_err"},     44'(err),           44'(ee));
        check({tag, "_done"},    44'(done),          44'(ed));
        check({tag, "_cpu_rst"}, 44'(cpu_rst),       44'(ec));
        check({tag, "_writes"},  44'(exp_q.size()),  44'h0);
    endtask

    task automatic apply_vec(input int i);
        for (int k = 0; k < vecs[i].nw; k++) exp_q.push_back(vecs[i].w[k]);
        for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].b[k], 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_status(vecs[i].name, vecs[i].e_err, vecs[i].e_done, vecs[i].e_cpu);
    endtask

    initial begin
        // T1 body; checksum 3C^01^00^01^00^21^08^20 = 0x35
        t1 = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01,
               8'h00, 8'h21, 8'h08, 8'h20};
        start_vec("t1_load", 1'b0, 1'b1, 1'b0);   add_t1(8'h35);  vecs[0] = cur;
        start_vec("t2_badcsum", 1'b1, 1'b0, 1'b1); add_t1(8'h34); vecs[1] = cur;
        start_vec("t3_n0", 1'b1, 1'b0, 1'b1);
        addb(8'hA5); addb(8'h00); addb(8'h00);                     vecs[2] = cur;
        start_vec("t3_n1001", 1'b1, 1'b0, 1'b1);
        addb(8'hA5); addb(8'h10); addb(8'h01);                     vecs[3] = cur;
        start_vec("t6_noise", 1'b0, 1'b1, 1'b0);
        addb(8'h00); addb(8'hFF); addb(8'h5A); add_t1(8'h35);      vecs[4] = cur;

        rise_seen    = 1'b0;
        done_at_rise = 1'b1;
        rxd   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_hold");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset("reset_idle");

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Short low glitch on an idle line while in DONE
        rxd = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check_status("t4_glitch", 1'b0, 1'b1, 1'b0);

        // Reload: sync byte alone reasserts cpu_rst and clears done together
        rise_seen = 1'b0;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_reload_rise", 44'(rise_seen), 44'h1);
        check("t5_reload_done_at_rise", 44'(done_at_rise), 44'h0);
        check_status("t5_reload", 1'b0, 1'b0, 1'b1);

        // Partial payload, then asynchronous reset in the middle of a byte
        exp_q.push_back({12'h000, 32'h3C010001});
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h3C, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_status("t5_partial", 1'b0, 1'b0, 1'b1);
        fork
            send_byte(8'h21, 1'b1);
            begin
                repeat (CPB * 4) @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_reset("t5_async_rst");
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        apply_vec(0);

        // N == WORD accepted: first word written, no error
        exp_q.push_back({12'h000, 32'h11223344});
        send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_status("t3_n1000", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Stop bit forced low on 2nd payload byte: error, no writes afterwards
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h21, 1'b1); send_byte(8'h08, 1'b1); send_byte(8'h20, 1'b1);
        send_byte(8'h35, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_status("t4_stop_err", 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
